// File: rtl/asynchronous_fifo.sv
// Single-clock FIFO with first-word-fall-through output and full/empty flags.
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst_n    - asynchronous active-low reset, clears both pointers
//   w_en     - write request, honoured when not full
//   r_en     - pop request, honoured when not empty
//   data_in  - write data
//   data_out - head word, zero while empty
//   full     - FIFO holds DEPTH words
//   empty    - FIFO holds no words
module asynchronous_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  // Pointers carry one extra wrap bit to tell full from empty.
  localparam int unsigned PW = PTR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  do_write;
  logic                  do_read;

  // Flag decode straight from the registered pointers.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
            (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]);
  end

  // Head word is visible without a pop; forced to zero when empty so
  // unwritten storage never reaches the output.
  always_comb begin
    data_out = '0;
    if (!empty) begin
      data_out = mem_q[rptr_q[PTR_WIDTH-1:0]];
    end
  end

  // Qualified requests and pointer next-state.
  always_comb begin
    do_write = w_en && !full;
    do_read  = r_en && !empty;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    if (do_write) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (do_read) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is intentionally not reset; the pointers alone define contents.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wptr_q[PTR_WIDTH-1:0]] <= data_in;
    end
  end

endmodule

// File: tb/tb_asynchronous_fifo.sv
module tb_asynchronous_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic          w_en;
  logic          r_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  int n_checks;
  int n_fails;

  // Reference model: plain queue bounded at DEPTH entries.
  logic [DW-1:0] q[$];

  asynchronous_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare DUT outputs against the model's view of the FIFO.
  task automatic check_state(input string name);
    logic          exp_empty;
    logic          exp_full;
    logic [DW-1:0] exp_data;
    exp_empty = (q.size() == 0);
    exp_full  = (q.size() == DEPTH);
    exp_data  = exp_empty ? '0 : q[0];
    n_checks++;
    if (empty !== exp_empty || full !== exp_full || data_out !== exp_data) begin
      n_fails++;
      $display("FAIL %s: got empty=%b full=%b data=%h, expected empty=%b full=%b data=%h",
               name, empty, full, data_out, exp_empty, exp_full, exp_data);
    end
  endtask

  // One clock: drive requests, update model at the edge, check at the negedge.
  task automatic cycle(input logic we, input logic re, input logic [DW-1:0] din);
    logic dw;
    logic dr;
    w_en    = we;
    r_en    = re;
    data_in = din;
    dw = we && (q.size() < DEPTH);
    dr = re && (q.size() > 0);
    @(posedge clk);
    if (dr) void'(q.pop_front());
    if (dw) q.push_back(din);
    @(negedge clk);
    w_en = 1'b0;
    r_en = 1'b0;
    check_state("cycle");
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      cycle(1'b0, 1'b1, '0);
      guard++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    w_en = 1'b0; r_en = 1'b0; data_in = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    #1;
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
      n_fails++;
      $display("FAIL reset: got empty=%b full=%b data=%h, expected 1 0 00", empty, full, data_out);
    end
  endtask

  task automatic test_ordered();
    cycle(1'b1, 1'b0, 8'hA5);
    n_checks++;
    if (data_out !== 8'hA5) begin
      n_fails++;
      $display("FAIL ordered_first: got %h expected a5", data_out);
    end
    cycle(1'b1, 1'b0, 8'h3C);
    cycle(1'b1, 1'b0, 8'h7E);
    cycle(1'b0, 1'b1, '0);
    n_checks++;
    if (data_out !== 8'h3C) begin
      n_fails++;
      $display("FAIL ordered_pop1: got %h expected 3c", data_out);
    end
    cycle(1'b0, 1'b1, '0);
    n_checks++;
    if (data_out !== 8'h7E) begin
      n_fails++;
      $display("FAIL ordered_pop2: got %h expected 7e", data_out);
    end
    cycle(1'b0, 1'b1, '0);
    n_checks++;
    if (empty !== 1'b1) begin
      n_fails++;
      $display("FAIL ordered_empty: got empty=%b expected 1", empty);
    end
  endtask

  task automatic test_fill_to_full();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, DW'(i));
    n_checks++;
    if (full !== 1'b1) begin
      n_fails++;
      $display("FAIL fill_full: got full=%b expected 1", full);
    end
    cycle(1'b1, 1'b0, 8'hFF);
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (data_out !== DW'(i)) begin
        n_fails++;
        $display("FAIL fill_drain: got %h expected %h", data_out, DW'(i));
      end
      cycle(1'b0, 1'b1, '0);
    end
    n_checks++;
    if (empty !== 1'b1 || data_out !== 8'h00) begin
      n_fails++;
      $display("FAIL fill_end: got empty=%b data=%h expected 1 00", empty, data_out);
    end
  endtask

  task automatic test_read_empty();
    cycle(1'b0, 1'b1, '0);
    n_checks++;
    if (data_out !== 8'h00 || empty !== 1'b1) begin
      n_fails++;
      $display("FAIL read_empty: got data=%h empty=%b expected 00 1", data_out, empty);
    end
    cycle(1'b1, 1'b0, 8'h55);
    n_checks++;
    if (data_out !== 8'h55 || empty !== 1'b0) begin
      n_fails++;
      $display("FAIL read_empty_write: got data=%h empty=%b expected 55 0", data_out, empty);
    end
    drain();
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, 1'b1, DW'($urandom));
      n_checks++;
      if (q.size() != 4 || empty !== 1'b0 || full !== 1'b0) begin
        n_fails++;
        $display("FAIL simul_occupancy: got model=%0d empty=%b full=%b expected 4 0 0",
                 q.size(), empty, full);
      end
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), DW'($urandom));
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), DW'($urandom));
    for (int i = 0; i < 30; i++) cycle(1'b1, ($urandom_range(0, 3) == 0), DW'($urandom));
    drain();
    n_checks++;
    if (empty !== 1'b1) begin
      n_fails++;
      $display("FAIL random_end: got empty=%b expected 1", empty);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
      n_fails++;
      $display("FAIL async_reset: got empty=%b full=%b data=%h expected 1 0 00",
               empty, full, data_out);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 8'h99);
    drain();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    test_reset();
    test_ordered();
    test_fill_to_full();
    test_read_empty();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
